div_scheduler: RTL

//  Shares one pipelined AXI-stream divider (div_gen_0, non-blocking, fixed latency) between N_CHAN

---
 rtl/div_sched_pkg.sv | 9 +
 rtl/div_sched_fifo.sv | 33 +++
 rtl/div_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types for the divider scheduler (tag entry, FSM state).
package div_sched_pkg;
   localparam int MAX_CHAN_W = 3;
   typedef enum logic {DRAIN, RUN} state_t;
   typedef struct packed {
      logic [MAX_CHAN_W-1:0] chan;
      logic                  divzero;
   } tag_t;
endpackage

// File: rtl/div_sched_fifo.sv
// div_sched_fifo: synchronous first-word-fall-through FIFO, DEPTH a power of 2.
module div_sched_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             full;
   assign empty_o = wr_q == rd_q;
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && (!full || pop_i)) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
            wr_q <= wr_q + 1'b1;
         end
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin sharing of one fixed-latency divider with credit flow control.
// Optional DIV_ZERO_GUARD_EN flags zero divisors and forces an all-ones quotient.
module div_scheduler
   import div_sched_pkg::*;
#(
   parameter int N_CHAN       = 2,
   parameter int DATA_SIZE    = 64,
   parameter int DOUT_SIZE    = 64,
   parameter int DIV_LATENCY  = 8,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [N_CHAN-1:0]             i_req_valid,
   output logic [N_CHAN-1:0]             o_req_ready,
   input  logic [N_CHAN*DATA_SIZE-1:0]   i_req_dividend,
   input  logic [N_CHAN*DATA_SIZE-1:0]   i_req_divisor,
   output logic                          o_div_tvalid,
   output logic [DATA_SIZE-1:0]          o_div_dividend,
   output logic [DATA_SIZE-1:0]          o_div_divisor,
   input  logic                          i_div_dout_valid,
   input  logic [DOUT_SIZE-1:0]          i_div_dout_data,
   output logic                          o_res_valid,
   input  logic                          i_res_ready,
   output logic [$clog2(N_CHAN)-1:0]     o_res_chan,
   output logic [DOUT_SIZE-1:0]          o_res_data,
   output logic                          o_err_orphan
`ifdef DIV_ZERO_GUARD_EN
   ,
   output logic                          o_res_divzero
`endif
);
   localparam int CHAN_W = $clog2(N_CHAN);
   localparam int CRED_W = $clog2(MAX_INFLIGHT) + 1;
   localparam int DRN_W  = $clog2(DIV_LATENCY) + 1;
   state_t                 state_q;
   logic [DRN_W-1:0]       drain_q;
   logic [CRED_W-1:0]      credits_q;
   logic [CHAN_W-1:0]      rr_q, gnt_idx;
   logic                   gnt_found, can_grant, xfer, ret, tag_pop, res_pop, tag_empty, res_empty;
   logic [DATA_SIZE-1:0]   sel_dvd, sel_dvs;
   logic [DOUT_SIZE-1:0]   ret_data, res_data;
   tag_t                   tag_in, tag_out, res_tag;
   logic                   unused;
   // rr_q is the first channel to consider, i.e. the one after the last grant
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = rr_q;
      for (int i = 0; i < N_CHAN; i++) begin
         if (!gnt_found && i_req_valid[CHAN_W'((int'(rr_q) + i) % N_CHAN)]) begin
            gnt_found = 1'b1;
            gnt_idx   = CHAN_W'((int'(rr_q) + i) % N_CHAN);
         end
      end
   end
   assign can_grant   = state_q == RUN && credits_q != '0;
   assign xfer        = can_grant && gnt_found;
   assign o_req_ready = xfer ? N_CHAN'(1) << gnt_idx : '0;
   assign sel_dvd     = i_req_dividend[gnt_idx*DATA_SIZE +: DATA_SIZE];
   assign sel_dvs     = i_req_divisor[gnt_idx*DATA_SIZE +: DATA_SIZE];
   always_comb begin
      tag_in.chan    = MAX_CHAN_W'(gnt_idx);
`ifdef DIV_ZERO_GUARD_EN
      tag_in.divzero = sel_dvs == '0;
`else
      tag_in.divzero = 1'b0;
`endif
   end
   assign ret     = state_q == RUN && i_div_dout_valid;
   assign tag_pop = ret && !tag_empty;
   assign res_pop = o_res_valid && i_res_ready;
`ifdef DIV_ZERO_GUARD_EN
   assign ret_data      = tag_out.divzero ? '1 : i_div_dout_data;
   assign o_res_divzero = o_res_valid && res_tag.divzero;
`else
   assign ret_data = i_div_dout_data;
`endif
   div_sched_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
      .clk_i(i_clock), .rst_ni(i_reset), .push_i(xfer), .din_i(tag_in),
      .pop_i(tag_pop), .dout_o(tag_out), .empty_o(tag_empty)
   );
   div_sched_fifo #(.WIDTH($bits(tag_t) + DOUT_SIZE), .DEPTH(MAX_INFLIGHT)) u_res_fifo (
      .clk_i(i_clock), .rst_ni(i_reset), .push_i(tag_pop), .din_i({tag_out, ret_data}),
      .pop_i(res_pop), .dout_o({res_tag, res_data}), .empty_o(res_empty)
   );
   assign o_res_valid = !res_empty;
   assign o_res_chan  = o_res_valid ? res_tag.chan[CHAN_W-1:0] : '0;
   assign o_res_data  = o_res_valid ? res_data : '0;
   assign unused      = ^res_tag;
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q        <= DRAIN;
         drain_q        <= '0;
         credits_q      <= CRED_W'(MAX_INFLIGHT);
         rr_q           <= '0;
         o_div_tvalid   <= 1'b0;
         o_div_dividend <= '0;
         o_div_divisor  <= '0;
         o_err_orphan   <= 1'b0;
      end else begin
         if (state_q == DRAIN) begin
            drain_q <= drain_q + 1'b1;
            if (drain_q == DRN_W'(DIV_LATENCY - 1)) state_q <= RUN;
         end
         credits_q    <= credits_q - CRED_W'(xfer) + CRED_W'(res_pop);
         o_div_tvalid <= xfer;
         if (xfer) begin
            o_div_dividend <= sel_dvd;
            o_div_divisor  <= sel_dvs;
            rr_q           <= gnt_idx == CHAN_W'(N_CHAN - 1) ? '0 : gnt_idx + 1'b1;
         end
         if (ret && tag_empty) o_err_orphan <= 1'b1;
      end
   end
endmodule
